// File: rtl/count_sequencer_if.sv
// Command handshake bundle between host control and count_sequencer.
interface count_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );
endinterface

// File: rtl/count_sequencer.sv
// Programmable prescaler and RUN/STOP/STEP/CLEAR sequencer
// for the 2-bit up/down display/phase counter.
module count_sequencer #(
    parameter int                   DIV_WIDTH   = 20,
    parameter logic [DIV_WIDTH-1:0] DIV_DEFAULT = 20'hFFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    count_sequencer_if.slave     cmd,
    input  logic                 dir,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic [1:0]           q,
    output logic                 tick,
    output logic                 wrap,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    state_t               state_q, state_d;
    logic [1:0]           q_q, q_d;
    logic [DIV_WIDTH-1:0] pre_q, pre_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 tick_q, tick_d;
    logic                 wrap_q, wrap_d;
    logic                 accept;
    logic                 upd;

    assign cmd.cmd_ready = (state_q != S_STEP);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            q_q     <= 2'd0;
            pre_q   <= '0;
            div_q   <= DIV_DEFAULT;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            pre_q   <= pre_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        upd     = 1'b0;
        // A load lands in div_q only; reloads below still see the old value.
        div_d   = div_load ? div_value : div_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_RUN: begin
                            state_d = S_RUN;
                            pre_d   = div_q;
                        end
                        OP_STEP: begin
                            state_d = S_STEP;
                            pre_d   = div_q;
                        end
                        OP_CLR:  q_d = 2'd0;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (accept && cmd.cmd_op == OP_STOP) begin
                    state_d = S_IDLE;
                end else if (accept && cmd.cmd_op == OP_CLR) begin
                    state_d = S_IDLE;
                    q_d     = 2'd0;
                end else begin
                    upd = (pre_q == '0);
                    if (!upd) pre_d = pre_q - DIV_WIDTH'(1);
                    // STEP arriving mid-run makes the pending update the last.
                    if (accept && cmd.cmd_op == OP_STEP)
                        state_d = upd ? S_IDLE : S_STEP;
                end
            end
            S_STEP: begin
                upd = (pre_q == '0);
                if (upd) state_d = S_IDLE;
                else     pre_d   = pre_q - DIV_WIDTH'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (upd) begin
            pre_d  = div_q;
            tick_d = 1'b1;
            q_d    = dir ? q_q + 2'd1 : q_q - 2'd1;
            wrap_d = dir ? (q_q == 2'd3) : (q_q == 2'd0);
        end
    end

    assign q    = q_q;
    assign tick = tick_q;
    assign wrap = wrap_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed vector bench for count_sequencer (8-bit divider, default 6).
module tb_count_sequencer;

    localparam int DW = 8;
    localparam logic [DW-1:0] DDEF = 8'd6;

    logic          clk = 1'b0;
    logic          reset;
    logic          dir;
    logic          div_load;
    logic [DW-1:0] div_value;
    logic [1:0]    q;
    logic          tick;
    logic          wrap;
    logic          busy;

    count_sequencer_if cmd_if ();

    count_sequencer #(
        .DIV_WIDTH   (DW),
        .DIV_DEFAULT (DDEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_if),
        .dir       (dir),
        .div_load  (div_load),
        .div_value (div_value),
        .q         (q),
        .tick      (tick),
        .wrap      (wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [1:0]    op;
        logic          dir;
        logic          ld;
        logic [DW-1:0] dv;
        logic          rn;
        logic [1:0]    q;
        logic          t;
        logic          w;
        logic          b;
        logic          r;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(
        input logic v, input logic [1:0] op, input logic d,
        input logic ld, input logic [DW-1:0] dv, input logic rn,
        input logic [1:0] eq, input logic et, input logic ew,
        input logic eb, input logic er
    );
        vec_t e;
        e.v = v; e.op = op; e.dir = d; e.ld = ld; e.dv = dv; e.rn = rn;
        e.q = eq; e.t = et; e.w = ew; e.b = eb; e.r = er;
        vecs.push_back(e);
    endfunction

    task automatic drive(
        input logic v, input logic [1:0] op, input logic d,
        input logic ld, input logic [DW-1:0] dv, input logic rn
    );
        @(negedge clk);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        dir              = d;
        div_load         = ld;
        div_value        = dv;
        reset            = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {q, tick, wrap, busy, cmd_if.cmd_ready};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got q=%0d tick=%b wrap=%b busy=%b ready=%b, want q=%0d tick=%b wrap=%b busy=%b ready=%b",
                     name, got[5:4], got[3], got[2], got[1], got[0],
                     exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        int lat;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        dir              = 1'b1;
        div_load         = 1'b0;
        div_value        = '0;
        reset            = 1'b0;

        // reset (overriding a RUN), then idle
        add(1, 2'd1, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1);

        // divider 3, RUN up for 20 cycles, then STOP and CLEAR
        add(0, 0, 1, 1, 8'd3, 1,  0, 0, 0, 0, 1);
        add(1, 2'd1, 1, 0, 0, 1,  0, 0, 0, 1, 1);
        for (int k = 1; k <= 20; k++)
            add(0, 0, 1, 0, 0, 1,  2'((k / 4) % 4), (k % 4) == 0,
                k == 16, 1, 1);
        add(1, 2'd0, 1, 0, 0, 1,  1, 0, 0, 0, 1);
        add(1, 2'd3, 1, 0, 0, 1,  0, 0, 0, 0, 1);

        // divider 2, STEP with RUN held valid during the step
        add(0, 0, 1, 1, 8'd2, 1,  0, 0, 0, 0, 1);
        add(1, 2'd2, 1, 0, 0, 1,  0, 0, 0, 1, 0);
        add(1, 2'd1, 1, 0, 0, 1,  0, 0, 0, 1, 0);
        add(1, 2'd1, 1, 0, 0, 1,  0, 0, 0, 1, 0);
        add(1, 2'd1, 1, 0, 0, 1,  1, 1, 0, 0, 1);
        add(1, 2'd1, 1, 0, 0, 1,  1, 0, 0, 1, 1);
        add(1, 2'd0, 1, 0, 0, 1,  1, 0, 0, 0, 1);
        add(1, 2'd3, 1, 0, 0, 1,  0, 0, 0, 0, 1);

        // divider 5 down from 0, reload value changed to 1 mid-countdown
        add(0, 0, 0, 1, 8'd5, 1,  0, 0, 0, 0, 1);
        add(1, 2'd1, 0, 0, 0, 1,  0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1,     0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 8'd1, 1,  0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1,     0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1,     0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1,     0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1,     3, 1, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1,     3, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1,     2, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1,     2, 0, 0, 1, 1);
        // STOP on the edge where the prescaler is 0: no update
        add(1, 2'd0, 0, 0, 0, 1,  2, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            add(0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 1);
        add(1, 2'd3, 0, 0, 0, 1,  0, 0, 0, 0, 1);

        // divider 0: update every cycle, then reset mid-run
        add(0, 0, 1, 1, 8'd0, 1,  0, 0, 0, 0, 1);
        add(1, 2'd1, 1, 0, 0, 1,  0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 1,     1, 1, 0, 1, 1);
        add(0, 0, 1, 0, 0, 1,     2, 1, 0, 1, 1);
        add(0, 0, 1, 0, 0, 1,     3, 1, 0, 1, 1);
        add(0, 0, 1, 0, 0, 1,     0, 1, 1, 1, 1);
        add(1, 2'd1, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            add(0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1);
        // divider back at default 6: first update 7 cycles after accept
        add(1, 2'd1, 1, 0, 0, 1,  0, 0, 0, 1, 1);
        for (int k = 1; k <= 6; k++)
            add(0, 0, 1, 0, 0, 1,  0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 1,     1, 1, 0, 1, 1);
        add(1, 2'd0, 1, 0, 0, 1,  1, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].dir,
                  vecs[i].ld, vecs[i].dv, vecs[i].rn);
            chk($sformatf("vec%0d", i),
                {vecs[i].q, vecs[i].t, vecs[i].w, vecs[i].b, vecs[i].r});
        end

        // reset during STEP, with RUN presented on the reset edge
        drive(0, 2'd0, 1, 1, 8'd4, 1);
        drive(1, 2'd2, 1, 0, 0, 1);
        chk("step_accept", {2'd1, 1'b0, 1'b0, 1'b1, 1'b0});
        drive(0, 2'd0, 1, 0, 0, 1);
        drive(1, 2'd1, 1, 0, 0, 0);
        chk("step_reset", {2'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < 8; i++) begin
            drive(0, 2'd0, 1, 0, 0, 1);
            chk($sformatf("post_reset%0d", i), 6'b000001);
        end

        // latency with divider 1, counting down from 0
        drive(0, 2'd0, 0, 1, 8'd1, 1);
        drive(1, 2'd1, 0, 0, 0, 1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            drive(0, 2'd0, 0, 0, 0, 1);
            if (tick === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_vec++;
        if (lat != 2) begin
            n_err++;
            $display("FAIL div1_latency got %0d cycles, want 2 (0 = no tick in 10)", lat);
        end
        chk("div1_first", {2'd3, 1'b1, 1'b1, 1'b1, 1'b1});
        drive(1, 2'd0, 0, 0, 0, 1);
        chk("div1_stop", {2'd3, 1'b0, 1'b0, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Clock-enable scheduler and controller for the 2-bit display/phase counter. It replaces the rippled divided clock with a single-clock programmable prescaler that issues one-cycle count ticks. It also sequences a 2-bit up/down counter through RUN, STOP, single-STEP and CLEAR commands. The block sits between the host control logic (command handshake) and the downstream logic that consumes `q`, `tick` and `wrap`.

## Interface

- `DIV_WIDTH`, default 20: prescaler width in bits.
- `DIV_DEFAULT`, default 20'hFFFFF: divider reload value after reset; tick period = reload + 1 cycles.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `reset` input 1: reset is synchronous and active-low.
- `cmd_valid` input 1: a command is present on `cmd_op`.
- `cmd_ready` output 1: the block can accept a command this cycle.
- `cmd_op` input 2: 00 STOP, 01 RUN, 10 STEP, 11 CLEAR.
- `dir` input 1: 1 = count up, 0 = count down; sampled at each count update.
- `div_load` input 1: load `div_value` into the divider register.
- `div_value` input DIV_WIDTH: new reload value.
- `q` output 2: counter value.
- `tick` output 1: one-cycle pulse, high in the cycle after each count update.
- `wrap` output 1: one-cycle pulse coincident with `tick` when the count wrapped (3→0 up, 0→3 down).
- `busy` output 1: high when the state is not IDLE.

## Operation

- States are IDLE, RUN and STEP.
- Reset (`reset`=0 at a rising edge) sets:
  - state = IDLE, `q`=0, prescaler=0, divider register=DIV_DEFAULT;
  - `tick`=0, `wrap`=0, `busy`=0, `cmd_ready`=1.
- Reset overrides every command in the same cycle, including mid-RUN and mid-STEP.
- Handshake:
  - A command is accepted when `cmd_valid`=1 and `cmd_ready`=1 at a rising edge.
  - `cmd_ready` = 1 in IDLE and RUN, and 0 in STEP.
  - `cmd_op` may change freely while it is not being accepted.
- Commands in IDLE:
  - RUN → state RUN, prescaler ← divider register.
  - STEP → state STEP, prescaler ← divider register.
  - STOP → no effect.
  - CLEAR → `q`←0.
- Commands in RUN:
  - STOP → state IDLE; `q` holds; prescaler frozen and reloaded on the next RUN/STEP.
  - RUN → no-op; the countdown is not restarted.
  - STEP → state STEP; the countdown continues, and the next update is the final one.
  - CLEAR → `q`←0, state IDLE, no tick in that cycle.
- Prescaler, in RUN and STEP:
  - If prescaler ≠ 0, it decrements by 1.
  - If prescaler = 0, a count update occurs and the prescaler ← divider register.
- Count update:
  - `q` ← `q`+1 if `dir`=1, or `q`−1 if `dir`=0, modulo 4.
  - `tick`←1 for one cycle; `wrap`←1 if the count wrapped, else 0.
- STEP: on its single count update, state ← IDLE.
- `div_load`:
  - Accepted in any state except during reset.
  - The divider register updates on that edge; the running countdown is not disturbed.
  - The new value takes effect at the next reload.
  - `div_load` coincident with a reload: the reload uses the old value.
- Divider value 0: an update occurs on every cycle in RUN.

## Timing

- A command accepted at edge E0 with divider register D gives its first count update at edge E(D+1). `tick` and `wrap` are high during the cycle after E(D+1).
- Subsequent updates in RUN every D+1 cycles.
- All outputs are registered; there is no combinational path from any input to any output, except `cmd_ready`, which is a function of state only.
- `busy` falls on the same edge that the STEP's update occurs.
- STOP accepted at the same edge the prescaler reaches 0: STOP wins and no update occurs.

## Test plan

- Reset, then idle 5 cycles → `q`=0, `tick`=0, `wrap`=0, `busy`=0, `cmd_ready`=1 throughout.
- `div_load` 3, RUN, `dir`=1 for 20 cycles → `tick` every 4 cycles, first 4 cycles after accept; `q` sequence 1,2,3,0,1; `wrap` only with the 3→0 tick.
- Divider 2, STEP, `cmd_valid` held high with RUN during STEP:
  - `cmd_ready`=0 for 3 cycles;
  - one update, `q` 0→1;
  - `busy` drops;
  - then RUN is accepted.
- RUN with divider 5, `dir`=0 from `q`=0 → first update `q`=3 with `wrap`=1. `div_load` 1 mid-countdown → current period stays 6 cycles, next periods are 2 cycles.
- RUN, then STOP at `q`=2 → `q` holds 2 for 10 cycles, no ticks. CLEAR → `q`=0, `busy`=0.
- RUN, divider 0, then `reset`=0 for one cycle mid-run → all outputs return to reset values the next cycle, divider = DIV_DEFAULT, no further ticks.
